// File: rtl/axis_frame_rr_arbiter.sv
// Frame-granular round-robin merge of S_COUNT AXI4-Stream sources onto one master.
// Output is a two-entry register/skid pair; m_axis_tid carries the source index.
//   state | meaning
//   IDLE  | no grant held; pick next valid source after last_grant
//   GRANT | forwarding one frame from grant_index until its tlast beat
module axis_frame_rr_arbiter #(
    parameter int S_COUNT     = 4,
    parameter int DATA_WIDTH  = 8,
    parameter bit KEEP_ENABLE = (DATA_WIDTH > 8),
    parameter int KEEP_WIDTH  = ((DATA_WIDTH + 7) / 8),
    parameter int USER_WIDTH  = 1,
    parameter int CL_S_COUNT  = $clog2(S_COUNT)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [S_COUNT*DATA_WIDTH-1:0]  s_axis_tdata,
    input  logic [S_COUNT*KEEP_WIDTH-1:0]  s_axis_tkeep,
    input  logic [S_COUNT-1:0]             s_axis_tvalid,
    output logic [S_COUNT-1:0]             s_axis_tready,
    input  logic [S_COUNT-1:0]             s_axis_tlast,
    input  logic [S_COUNT*USER_WIDTH-1:0]  s_axis_tuser,
    output logic [DATA_WIDTH-1:0]          m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]          m_axis_tkeep,
    output logic                           m_axis_tvalid,
    input  logic                           m_axis_tready,
    output logic                           m_axis_tlast,
    output logic [CL_S_COUNT-1:0]          m_axis_tid,
    output logic [USER_WIDTH-1:0]          m_axis_tuser,
    output logic [CL_S_COUNT-1:0]          grant_index,
    output logic                           busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [KEEP_WIDTH-1:0] keep;
        logic                  last;
        logic [CL_S_COUNT-1:0] id;
        logic [USER_WIDTH-1:0] user;
    } beat_t;

    localparam logic [CL_S_COUNT-1:0] LAST_IDX = CL_S_COUNT'(S_COUNT - 1);

    state_t                  state_q, state_d;
    logic [CL_S_COUNT-1:0]   grant_q, grant_d;
    logic [CL_S_COUNT-1:0]   last_grant_q, last_grant_d;
    logic                    out_valid_q, out_valid_d;
    beat_t                   out_q, out_d;
    logic                    skid_valid_q, skid_valid_d;
    beat_t                   skid_q, skid_d;

    logic                    sel_found;
    logic [CL_S_COUNT-1:0]   sel_idx;
    int                      idx;
    beat_t                   in_beat;
    logic                    accept;

    // Rotating search starting just after the last granted source.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        idx       = 0;
        for (int off = 1; off <= S_COUNT; off++) begin
            idx = (int'(last_grant_q) + off) % S_COUNT;
            if (!sel_found && s_axis_tvalid[idx]) begin
                sel_found = 1'b1;
                sel_idx   = CL_S_COUNT'(idx);
            end
        end
    end

    // Keep is forced to all-ones when keep propagation is disabled.
    always_comb begin
        in_beat.data = s_axis_tdata[grant_q*DATA_WIDTH +: DATA_WIDTH];
        in_beat.keep = s_axis_tkeep[grant_q*KEEP_WIDTH +: KEEP_WIDTH]
                       | {KEEP_WIDTH{!KEEP_ENABLE}};
        in_beat.last = s_axis_tlast[grant_q];
        in_beat.id   = grant_q;
        in_beat.user = s_axis_tuser[grant_q*USER_WIDTH +: USER_WIDTH];
    end

    // Ready depends only on registered state, never on m_axis_tready.
    always_comb begin
        s_axis_tready = '0;
        if (state_q == GRANT) begin
            s_axis_tready[grant_q] = ~skid_valid_q;
        end
    end

    assign accept = (state_q == GRANT) && s_axis_tvalid[grant_q] && !skid_valid_q;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (sel_found) begin
                    state_d      = GRANT;
                    grant_d      = sel_idx;
                    last_grant_d = sel_idx;
                end
            end
            GRANT: begin
                if (accept && in_beat.last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Skid contents always drain first; accept is impossible while skid is full.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_d        = out_q;
        skid_valid_d = skid_valid_q;
        skid_d       = skid_q;
        if (!out_valid_q || m_axis_tready) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_d        = skid_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_valid_d = 1'b1;
                out_d       = in_beat;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_d       = in_beat;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= LAST_IDX;
            out_valid_q  <= 1'b0;
            out_q        <= '0;
            skid_valid_q <= 1'b0;
            skid_q       <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            out_valid_q  <= out_valid_d;
            out_q        <= out_d;
            skid_valid_q <= skid_valid_d;
            skid_q       <= skid_d;
        end
    end

    assign m_axis_tvalid = out_valid_q;
    assign m_axis_tdata  = out_q.data;
    assign m_axis_tkeep  = out_q.keep;
    assign m_axis_tlast  = out_q.last;
    assign m_axis_tid    = out_q.id;
    assign m_axis_tuser  = out_q.user;
    assign grant_index   = grant_q;
    assign busy          = (state_q == GRANT);

endmodule

// File: tb/tb_axis_frame_rr_arbiter.sv
// Directed and randomized checks of axis_frame_rr_arbiter against a frame-level
// reference model: per-source beat queues plus an expected frame order.
module tb_axis_frame_rr_arbiter;
    localparam int S  = 4;
    localparam int DW = 8;
    localparam int KW = 1;
    localparam int UW = 1;
    localparam int CL = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [S*DW-1:0] s_tdata;
    logic [S*KW-1:0] s_tkeep;
    logic [S-1:0]    s_tvalid;
    logic [S-1:0]    s_tready;
    logic [S-1:0]    s_tlast;
    logic [S*UW-1:0] s_tuser;
    logic [DW-1:0]   m_tdata;
    logic [KW-1:0]   m_tkeep;
    logic            m_tvalid;
    logic            m_tready;
    logic            m_tlast;
    logic [CL-1:0]   m_tid;
    logic [UW-1:0]   m_tuser;
    logic [CL-1:0]   grant_index;
    logic            busy;

    always #5 clk = ~clk;

    axis_frame_rr_arbiter #(
        .S_COUNT(S), .DATA_WIDTH(DW), .USER_WIDTH(UW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready), .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
        .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_tready), .m_axis_tlast(m_tlast), .m_axis_tid(m_tid),
        .m_axis_tuser(m_tuser), .grant_index(grant_index), .busy(busy)
    );

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic       user;
        logic       first;
    } beat_t;

    beat_t src_q [S][$];
    beat_t exp_q [S][$];
    int    exp_order[$];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    bit in_frame;
    int cur_src;
    int s_acc, m_out;
    bit prev_stall;
    logic [12:0] saved;
    int last_out_cyc, first_out_cyc;
    bit gap_check = 0;
    bit rand_mode = 0;
    int rdy_mode = 0;
    int pat = 0;
    logic [3:0] pat_bits = 4'b1001;
    logic [S-1:0] hold, pop_pending, popped;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_frame(input int src, input int len, input logic [7:0] base, input bit rnd);
        beat_t b;
        for (int k = 0; k < len; k++) begin
            b.data  = rnd ? 8'($urandom_range(0, 255)) : 8'(base + k);
            b.last  = (k == len - 1);
            b.user  = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
            b.first = (k == 0);
            src_q[src].push_back(b);
            exp_q[src].push_back(b);
        end
        exp_order.push_back(src);
    endtask

    task automatic drive();
        logic v;
        for (int i = 0; i < S; i++) begin
            if (src_q[i].size() == 0 || hold[i]) v = 1'b0;
            else if (s_tvalid[i] && !popped[i]) v = 1'b1;
            else if (rand_mode && !src_q[i][0].first && $urandom_range(0, 2) == 0) v = 1'b0;
            else v = 1'b1;
            s_tvalid[i] = v;
            s_tdata[i*DW +: DW] = v ? src_q[i][0].data : 8'h00;
            s_tlast[i] = v ? src_q[i][0].last : 1'b0;
            s_tuser[i] = v ? src_q[i][0].user : 1'b0;
            popped[i] = 1'b0;
        end
        s_tkeep = '0;
        if (rdy_mode == 1) begin
            m_tready = pat_bits[pat % 4];
            pat++;
        end else if (rdy_mode == 2) begin
            m_tready = ($urandom_range(0, 9) < 7);
        end else begin
            m_tready = 1'b1;
        end
    endtask

    task automatic clear();
        for (int i = 0; i < S; i++) begin
            src_q[i].delete();
            exp_q[i].delete();
        end
        exp_order.delete();
        in_frame = 0; s_acc = 0; m_out = 0; prev_stall = 0;
        last_out_cyc = -1; first_out_cyc = -1;
        hold = '0; pop_pending = '0; popped = '0; s_tvalid = '0;
    endtask

    task automatic monitor();
        beat_t b;
        int held;
        if (!rst_n) begin
            prev_stall = 0;
            return;
        end
        held = s_acc - m_out;
        chk("storage_overflow", 32'(held > 2), 0);
        if (held == 2) chk("s_tready_when_full", 32'(s_tready), 0);
        if (prev_stall) chk("stall_hold", 32'({m_tvalid, m_tdata, m_tlast, m_tid, m_tuser}), 32'(saved));
        for (int i = 0; i < S; i++) begin
            if (s_tvalid[i] && s_tready[i]) begin
                pop_pending[i] = 1'b1;
                s_acc++;
            end
        end
        if (m_tvalid && m_tready) begin
            if (!in_frame) begin
                chk("frame_pending", 32'(exp_order.size() > 0), 1);
                if (exp_order.size() == 0) return;
                cur_src = exp_order.pop_front();
                in_frame = 1;
                if (gap_check && last_out_cyc >= 0) chk("bubble", 32'(cyc - last_out_cyc), 2);
            end
            chk("tid", 32'(m_tid), 32'(cur_src));
            chk("beat_pending", 32'(exp_q[cur_src].size() > 0), 1);
            if (exp_q[cur_src].size() == 0) return;
            b = exp_q[cur_src].pop_front();
            chk("tdata", 32'(m_tdata), 32'(b.data));
            chk("tlast", 32'(m_tlast), 32'(b.last));
            chk("tuser", 32'(m_tuser), 32'(b.user));
            chk("tkeep", 32'(m_tkeep), 1);
            m_out++;
            if (first_out_cyc < 0) first_out_cyc = cyc;
            if (b.last) begin
                in_frame = 0;
                last_out_cyc = cyc;
            end
        end
        prev_stall = m_tvalid && !m_tready;
        saved = {m_tvalid, m_tdata, m_tlast, m_tid, m_tuser};
    endtask

    task automatic cycle();
        @(negedge clk);
        monitor();
        @(posedge clk);
        cyc++;
        #1;
        for (int i = 0; i < S; i++) begin
            if (pop_pending[i]) begin
                void'(src_q[i].pop_front());
                popped[i] = 1'b1;
                pop_pending[i] = 1'b0;
            end
        end
        drive();
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        clear();
        drive();
        repeat (n) cycle();
        rst_n = 1'b1;
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while ((exp_order.size() != 0 || in_frame) && n < budget) begin
            cycle();
            n++;
        end
        chk({tag, "_drained"}, 32'(exp_order.size() == 0 && !in_frame), 1);
    endtask

    initial begin
        int n;
        int start;
        s_tdata = '0; s_tkeep = '0; s_tvalid = '0; s_tlast = '0; s_tuser = '0;
        m_tready = 1'b1;

        // 1: reset values, single 4-beat frame and latency
        do_reset(3);
        chk("rst_tvalid", 32'(m_tvalid), 0);
        chk("rst_tdata", 32'(m_tdata), 0);
        chk("rst_tlast", 32'(m_tlast), 0);
        chk("rst_tid", 32'(m_tid), 0);
        chk("rst_tuser", 32'(m_tuser), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_grant", 32'(grant_index), 0);
        chk("rst_s_tready", 32'(s_tready), 0);
        cycle();
        chk("idle_tvalid", 32'(m_tvalid), 0);
        chk("idle_busy", 32'(busy), 0);
        push_frame(0, 4, 8'h10, 0);
        drive();
        start = cyc;
        drain("t1", 40);
        chk("t1_latency", 32'(first_out_cyc - start), 2);

        // 2: round-robin rotation with one bubble between frames
        do_reset(2);
        gap_check = 1;
        push_frame(0, 2, 8'h20, 0);
        push_frame(1, 2, 8'h30, 0);
        push_frame(2, 2, 8'h40, 0);
        push_frame(3, 2, 8'h50, 0);
        push_frame(0, 2, 8'h60, 0);
        drive();
        drain("t2", 60);
        gap_check = 0;

        // 3: granted source stalls mid-frame, other source must wait
        do_reset(2);
        push_frame(2, 4, 8'h70, 0);
        drive();
        n = 0;
        while (!busy && n < 10) begin cycle(); n++; end
        chk("t3_granted", 32'(busy), 1);
        push_frame(1, 2, 8'h80, 0);
        drive();
        n = 0;
        while (src_q[2].size() > 2 && n < 20) begin cycle(); n++; end
        hold[2] = 1'b1;
        drive();
        repeat (5) begin
            cycle();
            chk("t3_grant_held", 32'(grant_index), 2);
            chk("t3_s1_not_ready", 32'(s_tready[1]), 0);
        end
        hold[2] = 1'b0;
        drive();
        drain("t3", 40);

        // 4: backpressure pattern 1,0,0,1 over an 8-beat frame
        do_reset(2);
        rdy_mode = 1;
        pat = 0;
        push_frame(3, 8, 8'h90, 0);
        drive();
        drain("t4", 80);
        rdy_mode = 0;
        drive();

        // 5: reset mid-frame restores priority to source 0
        do_reset(2);
        push_frame(1, 6, 8'hA0, 0);
        drive();
        n = 0;
        while (src_q[1].size() > 3 && n < 20) begin cycle(); n++; end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear();
        drive();
        @(negedge clk);
        chk("t5_tvalid", 32'(m_tvalid), 0);
        chk("t5_busy", 32'(busy), 0);
        chk("t5_grant", 32'(grant_index), 0);
        push_frame(0, 2, 8'hB0, 0);
        push_frame(2, 2, 8'hC0, 0);
        drive();
        drain("t5", 40);

        // 6: randomized frames, gaps and backpressure; keep checked on every beat
        do_reset(2);
        rand_mode = 1;
        rdy_mode = 2;
        for (int r = 0; r < 10; r++) begin
            for (int s = 0; s < S; s++) push_frame(s, int'($urandom_range(1, 5)), 8'h00, 1);
        end
        drive();
        drain("rand", 4000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/axis_frame_rr_arbiter.md
Name: axis_frame_rr_arbiter

Overview:
- Round-robin, frame-granular arbiter that merges S_COUNT AXI4-Stream sources onto one master stream.
- Sits upstream of axis_async_fifo_adapter, so several producers in one clock domain can share a single width-converting CDC FIFO.
- A grant is held from the first beat of a frame through its tlast beat, so frames never interleave.
- The output is registered and skid-buffered. The source index is placed on m_axis_tid.

Parameters:
- S_COUNT, 4, number of input streams (2..16).
- DATA_WIDTH, 8, tdata width per stream.
- KEEP_ENABLE, (DATA_WIDTH>8), propagate tkeep; when 0, m_axis_tkeep is driven all-ones.
- KEEP_WIDTH, ((DATA_WIDTH+7)/8), tkeep width.
- USER_WIDTH, 1, tuser width.
- CL_S_COUNT, $clog2(S_COUNT), width of the grant index and of m_axis_tid.

Ports:
- clk  in  1  single clock for the whole block.
- rst_n  in  1  synchronous, active-low reset.
- s_axis_tdata  in  S_COUNT*DATA_WIDTH  packed; stream i occupies slice [i*DATA_WIDTH +: DATA_WIDTH].
- s_axis_tkeep  in  S_COUNT*KEEP_WIDTH  packed.
- s_axis_tvalid  in  S_COUNT  per-stream valid.
- s_axis_tready  out  S_COUNT  per-stream ready.
- s_axis_tlast  in  S_COUNT  per-stream last.
- s_axis_tuser  in  S_COUNT*USER_WIDTH  packed.
- m_axis_tdata  out  DATA_WIDTH  merged data.
- m_axis_tkeep  out  KEEP_WIDTH  merged keep.
- m_axis_tvalid  out  1  merged valid.
- m_axis_tready  in  1  merged ready.
- m_axis_tlast  out  1  merged last.
- m_axis_tid  out  CL_S_COUNT  index of the source that produced the beat.
- m_axis_tuser  out  USER_WIDTH  merged user.
- grant_index  out  CL_S_COUNT  currently granted source.
- busy  out  1  high while in the GRANT state.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n.
- Reset values (rst_n low at a clk edge):
  - state=IDLE, busy=0, grant_index=0.
  - last_grant=S_COUNT-1, so source 0 has first priority.
  - s_axis_tready=0.
  - m_axis_tvalid=0, skid buffer empty.
  - m_axis_tdata, tkeep, tlast, tid and tuser all 0.
- FSM has two states, IDLE and GRANT.
- IDLE:
  - If any s_axis_tvalid is set, select the first valid index searching upward from last_grant+1, modulo S_COUNT.
  - Register the selection into grant_index and last_grant, and go to GRANT on the next clk. busy rises in that cycle.
  - If no source is valid, stay in IDLE.
- GRANT:
  - s_axis_tready[grant_index] = ~skid_valid.
  - All other bits of s_axis_tready are 0.
  - s_axis_tready is a combinational function of registered state only. It never depends on m_axis_tready combinationally.
  - When the granted source's tvalid and tready are both high, the beat is accepted.
  - An accepted beat with tlast=1 moves the FSM to IDLE on that clk edge.
  - This costs exactly one arbitration bubble cycle between frames.
- Output stage (two entries: output register plus skid register):
  - An accepted beat appears on m_axis_* on the next clk, so latency is 1 cycle. m_axis_tid carries grant_index.
  - If the output register is full and m_axis_tready=0 when a beat is accepted, the beat goes to the skid register. skid_valid then deasserts s_axis_tready.
  - When the output register drains, the skid contents move to the output register on the same edge.
  - Throughput is 1 beat/clk while m_axis_tready=1.
- m_axis_* hold stable while m_axis_tvalid=1 and m_axis_tready=0 (AXI rule).
- Fairness: after a frame from source k, sources k+1..S_COUNT-1 and then 0..k are searched in that order. A source that is continuously valid is therefore served within S_COUNT frames.
- A source that deasserts tvalid mid-frame keeps the grant, however long it stalls. There is no timeout.
- If the granted source's tvalid drops before tlast, the FSM waits in GRANT.
- Changes on non-granted inputs during GRANT are ignored.
- Reset in mid-frame: on the next edge all state returns to reset values and any beats held in the output or skid register are discarded. A partial frame may have been emitted; downstream frame FIFO drop logic handles it.
- KEEP_ENABLE=0: tkeep inputs are ignored and m_axis_tkeep is all-ones.
- S_COUNT must be a power of 2 or handled by the modulo wrap; the index wraps from S_COUNT-1 to 0.

Test Plan:
1. Reset and single source:
   - Stimulus: hold rst_n=0 for 3 clks, then source 0 sends a 4-beat frame with data 0x10..0x13, m_axis_tready=1.
   - Required: before the frame, all outputs are 0. m_axis_tvalid rises 2 clks after s_axis_tvalid (1 arbitration cycle + 1 output register). Data is 0x10..0x13, tid=0, tlast on 0x13 only.
2. Round-robin rotation:
   - Stimulus: sources 0..3 each continuously present 2-beat frames.
   - Required: output tid sequence is 0,0,1,1,2,2,3,3,0,0. Exactly one tvalid-low bubble appears between frames.
3. No interleaving:
   - Stimulus: source 2 is granted, then drops tvalid for 5 clks mid-frame while source 1 stays valid.
   - Required: no source 1 beat appears until the source 2 tlast beat has been output. grant_index stays at 2 throughout.
4. Backpressure:
   - Stimulus: during an 8-beat frame, m_axis_tready alternates 1,0,0,1.
   - Required: no beat is lost or duplicated. m_axis_* hold stable while stalled. s_axis_tready drops within 1 clk of the skid register filling.
5. Reset mid-frame:
   - Stimulus: assert rst_n=0 for 1 clk at beat 3 of a 6-beat frame from source 1.
   - Required: next clk shows m_axis_tvalid=0 and busy=0. Afterwards source 0 wins first arbitration (last_grant restored to S_COUNT-1).
6. Keep disabled:
   - Stimulus: KEEP_ENABLE=0 with s_axis_tkeep driven to 0.
   - Required: m_axis_tkeep is all-ones on every output beat.
